// File: rtl/sd_cmd_engine.sv
// SD command-line engine: sends a 48-bit command frame on CMD, optionally
// receives a 48/136-bit response and flags CRC7, index and timeout errors.
// clk_SD is derived from clk_host; all logic runs in the clk_host domain.
module sd_cmd_engine #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned NCR_MAX    = 64,
  parameter int unsigned NCC_CYCLES = 8
) (
  input  logic         clk_host,
  input  logic         reset_host,
  input  logic         new_command,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         cmd_complete,
  output logic         cmd_index_error,
  output logic         cmd_crc_error,
  output logic         cmd_timeout_error,
  output logic [127:0] response,
  output logic         clk_SD,
  output logic         CMD_PIN_OUT,
  output logic         io_enable_cmd,
  input  logic         CMD_PIN_IN
);

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);
  localparam logic [15:0] NcrLast = 16'(NCR_MAX - 1);
  localparam logic [15:0] NccLast = 16'(NCC_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSend, StWaitResp, StRecv, StCheck, StNcc} state_e;

  state_e         state_q, state_d;
  logic [15:0]    div_q, cnt_q;
  logic           clk_sd_q, busy_q, cmd_complete_q;
  logic           idx_err_q, crc_err_q, to_err_q, pin_q, io_en_q;
  logic [127:0]   resp_q;
  logic [5:0]     idx_q;
  logic [1:0]     rtype_q;
  logic [39:0]    tx_sr_q;
  logic [6:0]     tx_crc_q, rx_crc_q;
  logic [127:0]   rx_sr_q;

  logic           div_wrap, fall_tick, rise_tick, accept, long_resp;
  logic           rx_shift, rx_crc_en, timeout;
  logic [15:0]    rx_last, rx_n;

  // Serial CRC7 step, polynomial x^7 + x^3 + 1
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign div_wrap  = (div_q == DivLast);
  assign fall_tick = div_wrap & clk_sd_q;
  assign rise_tick = div_wrap & ~clk_sd_q;
  assign accept    = (state_q == StIdle) && new_command && !busy_q;
  assign long_resp = (rtype_q == 2'b10);
  assign rx_last   = long_resp ? 16'd135 : 16'd47;
  // Start bit is taken in WAIT_RESP as received bit 0; RECV counts from 1
  assign rx_n      = (state_q == StWaitResp) ? 16'd0 : cnt_q;
  assign rx_shift  = rise_tick && ((state_q == StWaitResp && !CMD_PIN_IN) ||
                                   state_q == StRecv);
  assign rx_crc_en = long_resp ? (rx_n >= 16'd8 && rx_n <= 16'd127) : (rx_n <= 16'd39);
  assign timeout   = (state_q == StWaitResp) && rise_tick && CMD_PIN_IN &&
                     (cnt_q == NcrLast);

  assign busy              = busy_q;
  assign cmd_complete      = cmd_complete_q;
  assign cmd_index_error   = idx_err_q;
  assign cmd_crc_error     = crc_err_q;
  assign cmd_timeout_error = to_err_q;
  assign response          = resp_q;
  assign clk_SD            = clk_sd_q;
  assign CMD_PIN_OUT       = pin_q;
  assign io_enable_cmd     = io_en_q;

  // Free-running clk_SD divider
  always_ff @(posedge clk_host or negedge reset_host) begin
    if (!reset_host) begin
      div_q    <= '0;
      clk_sd_q <= 1'b0;
    end else if (div_wrap) begin
      div_q    <= '0;
      clk_sd_q <= ~clk_sd_q;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  // State register
  always_ff @(posedge clk_host or negedge reset_host) begin
    if (!reset_host) state_q <= StIdle;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (accept) state_d = StSend;
      StSend:     if (fall_tick && cnt_q == 16'd48) begin
                    state_d = (rtype_q == 2'b00) ? StNcc : StWaitResp;
                  end
      StWaitResp: if (rise_tick) begin
                    if (!CMD_PIN_IN)          state_d = StRecv;
                    else if (cnt_q == NcrLast) state_d = StNcc;
                  end
      StRecv:     if (rise_tick && cnt_q == rx_last) state_d = StCheck;
      StCheck:    state_d = StNcc;
      StNcc:      if (rise_tick && cnt_q == NccLast) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Per-state tick counter: bits sent, NCR ticks, bits received, NCC ticks
  always_ff @(posedge clk_host or negedge reset_host) begin
    if (!reset_host) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= (state_d == StRecv) ? 16'd1 : 16'd0;
    end else if ((state_q == StSend && fall_tick) ||
                 ((state_q == StWaitResp || state_q == StRecv || state_q == StNcc) &&
                  rise_tick)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Command latch, serialiser, deserialiser, result checks and status flags
  always_ff @(posedge clk_host or negedge reset_host) begin
    if (!reset_host) begin
      busy_q         <= 1'b0;
      cmd_complete_q <= 1'b0;
      idx_err_q      <= 1'b0;
      crc_err_q      <= 1'b0;
      to_err_q       <= 1'b0;
      resp_q         <= '0;
      pin_q          <= 1'b1;
      io_en_q        <= 1'b0;
      idx_q          <= '0;
      rtype_q        <= '0;
      tx_sr_q        <= '0;
      tx_crc_q       <= '0;
      rx_crc_q       <= '0;
      rx_sr_q        <= '0;
    end else begin
      cmd_complete_q <= 1'b0;
      if (accept) begin
        busy_q    <= 1'b1;
        idx_q     <= cmd_index;
        rtype_q   <= resp_type;
        tx_sr_q   <= {2'b01, cmd_index, cmd_argument};
        tx_crc_q  <= '0;
        rx_crc_q  <= '0;
        idx_err_q <= 1'b0;
        crc_err_q <= 1'b0;
        to_err_q  <= 1'b0;
      end
      if (state_q == StSend && fall_tick) begin
        if (cnt_q < 16'd40) begin
          io_en_q  <= 1'b1;
          pin_q    <= tx_sr_q[39];
          tx_sr_q  <= {tx_sr_q[38:0], 1'b0};
          tx_crc_q <= crc7_step(tx_crc_q, tx_sr_q[39]);
        end else if (cnt_q < 16'd47) begin
          pin_q    <= tx_crc_q[6];
          tx_crc_q <= {tx_crc_q[5:0], 1'b0};
        end else if (cnt_q == 16'd47) begin
          pin_q <= 1'b1;
        end else begin
          // End bit has completed: release the line
          pin_q   <= 1'b1;
          io_en_q <= 1'b0;
          if (rtype_q == 2'b00) cmd_complete_q <= 1'b1;
        end
      end
      if (rx_shift) begin
        rx_sr_q <= {rx_sr_q[126:0], CMD_PIN_IN};
        if (rx_crc_en) rx_crc_q <= crc7_step(rx_crc_q, CMD_PIN_IN);
      end
      if (timeout) begin
        to_err_q       <= 1'b1;
        cmd_complete_q <= 1'b1;
      end
      if (state_q == StCheck) begin
        cmd_complete_q <= 1'b1;
        if (long_resp) begin
          resp_q    <= {8'h00, rx_sr_q[127:8]};
          crc_err_q <= (rx_sr_q[7:1] != rx_crc_q);
        end else begin
          resp_q <= {96'h0, rx_sr_q[39:8]};
          if (rtype_q == 2'b01) begin
            crc_err_q <= (rx_sr_q[7:1] != rx_crc_q);
            idx_err_q <= (rx_sr_q[45:40] != idx_q);
          end
        end
      end
      if (state_q == StNcc && state_d == StIdle) busy_q <= 1'b0;
    end
  end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Parametrised SD command-line engine for the SD host: serialises a 48-bit command frame onto the CMD pin, optionally receives a 48-bit or 136-bit response, and checks it for CRC7, index and timeout errors. It generates the SD bus clock internally from the host clock, so one clock domain replaces the separate SD clock input. Command inputs and status outputs connect directly to the host register block.

## Interface
- CLK_DIV, 4: clk_SD half-period in clk_host cycles (≥1).
- NCR_MAX, 64: maximum clk_SD rising edges between command end bit and response start bit.
- NCC_CYCLES, 8: idle clk_SD cycles enforced after each transaction before busy drops.
- clk_host  in  1  host clock; all logic on rising edge.
- reset_host  in  1  asynchronous, active-low reset.
- new_command  in  1  start request; sampled only when busy=0.
- cmd_index  in  6  command index.
- cmd_argument  in  32  command argument.
- resp_type  in  2  00 none, 01 short with CRC/index check (R1/R6/R7), 10 long 136-bit (R2), 11 short without checks (R3).
- busy  out  1  transaction in progress.
- cmd_complete  out  1  one-cycle pulse at transaction end.
- cmd_index_error, cmd_crc_error, cmd_timeout_error  out  1 each  sticky until next accepted command.
- response  out  128  received response payload.
- clk_SD  out  1  SD bus clock.
- CMD_PIN_OUT  out  1  CMD line drive value.
- io_enable_cmd  out  1  1 = host drives CMD line.
- CMD_PIN_IN  in  1  CMD line input.

## Operation
- Divider: counter toggles clk_SD every CLK_DIV clk_host cycles and runs continuously. fall_tick marks the clk_host cycle in which clk_SD goes 1→0; rise_tick marks 0→1. Pin updates happen on fall_tick; CMD_PIN_IN is sampled on rise_tick.
- Acceptance: new_command=1 and busy=0 latches cmd_index, cmd_argument and resp_type. It clears all three error flags and sets busy. new_command is ignored while busy=1.
- Command frame, MSB first: 0, 1, index[5:0], argument[31:0], CRC7[6:0], 1.
- CRC7 uses polynomial x^7+x^3+1 with initial value 0 and covers the first 40 bits. It is computed serially alongside the bits shifted out.
- States: IDLE → SEND (48 bits, io_enable_cmd=1) → WAIT_RESP if resp_type≠00, else NCC. After the end bit, io_enable_cmd drops at the next fall_tick.
- WAIT_RESP counts rise_ticks. The first sampled 0 enters RECV. If NCR_MAX ticks pass without a 0: set cmd_timeout_error, go to NCC.
- RECV collects 48 bits (short) or 136 bits (long), including the start bit, then goes to CHECK for one clk_host cycle.
- Short result: response[31:0] = bits 39..8, response[127:32] = 0. For resp_type 01, received CRC7 (bits 7..1) is checked against the CRC over bits 47..8, and received index (bits 45..40) against the latched cmd_index. Mismatches set cmd_crc_error / cmd_index_error; both may set together. resp_type 11 performs no checks.
- Long result: response[119:0] = bits 127..8, response[127:120] = 0. CRC is computed over bits 127..8 and checked against bits 7..1. No index check.
- cmd_complete pulses on CHECK exit, on timeout, or on the fall_tick after the end bit when resp_type=00. Error flags are valid in the same cycle as the pulse.
- NCC: wait NCC_CYCLES rise_ticks, then busy=0 and return to IDLE.
- response holds its value until the next CHECK; it is not cleared on acceptance.

## Timing
- Reset values: busy 0, cmd_complete 0, all error flags 0, response 0, clk_SD 0, CMD_PIN_OUT 1, io_enable_cmd 0, state IDLE, divider 0.
- Reset mid-transaction forces these values immediately (asynchronously). The next command after release starts a fresh frame.
- busy rises in the clk_host cycle after acceptance. The start bit is driven at the first fall_tick after acceptance.
- Each bit lasts 2·CLK_DIV clk_host cycles.
- No-response latency: acceptance → cmd_complete ≈ 48 clk_SD periods. busy then stays high for NCC_CYCLES more clk_SD periods.
- When CMD_PIN_OUT is not being driven, it is held at 1.

## Test plan
- CMD0, argument 0, resp_type 00 → serial stream 0x40 00 00 00 00 95; cmd_complete after 48 bits; no errors; busy low after 8 further clk_SD cycles.
- CMD8, argument 0x000001AA, resp_type 01 → last frame byte 0x87. Bench replies 0x08 000001AA with a valid CRC after 5 clk_SD cycles → response[31:0] = 0x000001AA, no errors.
- Same as previous, with the reply index changed to 9 and one argument bit flipped → cmd_index_error=1 and cmd_crc_error=1 in the cmd_complete cycle.
- resp_type 10, bench sends a 136-bit R2 with payload 0x0123…EF and valid CRC → response[119:0] matches, [127:120] = 0, no errors. new_command pulsed mid-transfer is ignored.
- resp_type 01 with CMD_PIN_IN held at 1 → cmd_timeout_error=1 exactly NCR_MAX rise_ticks after the end bit.
- Assert reset_host during SEND → all outputs return to reset values immediately; a subsequent CMD0 produces a correct full frame.
